// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the MIPS HI/LO
// registers. It serves mult/multu/div/divu/mthi/mtlo, and busy stalls the
// controller while an operation is in flight.
// Optional feature macro MDU_DIV_EN: when it is defined, div/divu are built.
// When it is undefined, a div/divu start is ignored.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count;
  logic [63:0]   r_pend;      // result captured at launch, committed at the end
  logic          r_pend_wr;   // cleared for divide-by-zero: HI/LO keep their values
  logic [31:0]   r_hi, r_lo;

  logic          w_is_div, w_signed, w_op_ok, w_accept, w_last;
  logic [63:0]   w_mul_a, w_mul_b, w_mul_p;
  logic [63:0]   w_result;
  logic          w_result_wr;
  logic [CW-1:0] w_load;

  // op encoding: bit 1 selects divide, and bit 0 selects unsigned.
  assign w_is_div = op[1];
  assign w_signed = ~op[0];

  // The low 64 bits of a 64x64 product of the extended operands give the
  // exact signed or unsigned 32x32 product.
  assign w_mul_a = {{32{w_signed & a[31]}}, a};
  assign w_mul_b = {{32{w_signed & b[31]}}, b};
  assign w_mul_p = w_mul_a * w_mul_b;

`ifdef MDU_DIV_EN
  logic        w_neg_a, w_neg_b, w_b_zero;
  logic [31:0] w_abs_a, w_abs_b, w_div_b, w_quo, w_rem;

  // The signed divide runs on magnitudes, and the signs are fixed up
  // afterwards. The quotient then truncates toward zero, and the remainder
  // follows the dividend. The 0x80000000 / -1 case wraps to 0x80000000 with
  // a remainder of 0.
  assign w_neg_a  = w_signed & a[31];
  assign w_neg_b  = w_signed & b[31];
  assign w_abs_a  = w_neg_a ? (32'd0 - a) : a;
  assign w_abs_b  = w_neg_b ? (32'd0 - b) : b;
  assign w_b_zero = (b == 32'd0);
  assign w_div_b  = w_b_zero ? 32'd1 : w_abs_b;   // keeps the divider defined; result discarded
  assign w_quo    = w_abs_a / w_div_b;
  assign w_rem    = w_abs_a % w_div_b;
  assign w_op_ok  = 1'b1;
`else
  assign w_op_ok  = ~w_is_div;
`endif

  // Select the result to capture at launch, and select the busy length.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_result    = w_mul_p;
    w_result_wr = 1'b1;
    w_load      = CW'(MULT_CYCLES);
`ifdef MDU_DIV_EN
    if (w_is_div) begin
      w_result    = {(w_neg_a ? (32'd0 - w_rem) : w_rem),
                     ((w_neg_a ^ w_neg_b) ? (32'd0 - w_quo) : w_quo)};
      w_result_wr = ~w_b_zero;
      w_load      = CW'(DIV_CYCLES);
    end
`endif
  end

  assign w_accept = start && (r_state == S_IDLE) && w_op_ok;
  assign w_last   = (r_state == S_RUN) && (r_count == CW'(1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: launch on an accepted start, and return at terminal count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counter, pending result, HI/LO commit, and mthi/mtlo writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_count   <= w_load;
        r_pend    <= w_result;
        r_pend_wr <= w_result_wr;
      end else begin
        if (we_hi) r_hi <= wdata;
        if (we_lo) r_lo <= wdata;
      end
    end else if (w_last) begin
      r_count <= '0;
      if (r_pend_wr) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else begin
      r_count <= r_count - CW'(1);
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. The driver pushes the
// expected HI/LO and busy length when it launches an operation. A monitor
// pops and compares them whenever busy falls. The driver does direct checks
// for mthi/mtlo, ignored ops and reset.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        we_hi = 1'b0, we_lo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;   // architectural HI/LO of the reference model

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operands. It returns 1
  // when HI/LO are written.
  function automatic bit ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, res, q, r;
    rh = m_hi;
    rl = m_lo;
    sx = o[0] ? longint'({32'd0, x}) : longint'($signed(x));
    sy = o[0] ? longint'({32'd0, y}) : longint'($signed(y));
    if (o < 2'd2) begin
      res = sx * sy;
      rh  = res[63:32];
      rl  = res[31:0];
      return 1'b1;
    end
    if (y == 32'd0) return 1'b0;
    q  = sx / sy;
    r  = sx % sy;
    rl = q[31:0];
    rh = r[31:0];
    return 1'b1;
  endfunction

  // Monitor: on every busy falling edge, pop one expectation and compare it.
  initial begin : monitor
    int   run_len;
    logic prev;
    exp_t e;
    run_len = 0;
    prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len = 0;
        prev    = 1'b0;
      end else begin
        if (busy) run_len++;
        if (prev && !busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: busy fell with hi=%h lo=%h, none expected", hi, lo);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
            check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            check({e.name, "_busy_len"}, 64'(run_len), 64'(e.cycles));
          end
          run_len = 0;
        end
        prev = busy;
      end
    end
  end

  // mthi/mtlo while idle. The task starts and ends just after a negedge.
  task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
    we_hi = wh;
    we_lo = wl;
    wdata = d;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    @(negedge clk);
    we_hi = 1'b0;
    we_lo = 1'b0;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  // Launch one operation. An optional hazard pulses start and we_lo mid-run.
  // An optional collision asserts we_hi on the launch edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name, input bit hazard, input bit collide);
    logic [31:0] rh, rl;
    bit          accepted;
    exp_t        e;
    int          n;
    accepted = (o < 2'd2);
`ifdef MDU_DIV_EN
    accepted = 1'b1;
`endif
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (collide) begin
      we_hi = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    if (accepted) begin
      if (ref_op(o, x, y, rh, rl)) begin
        m_hi = rh;
        m_lo = rl;
      end
      e.hi     = m_hi;
      e.lo     = m_lo;
      e.cycles = (o < 2'd2) ? MC : DC;
      e.name   = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    we_hi = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (!accepted) begin
      check({name, "_ignored_busy"}, 64'(busy), 64'(0));
      repeat (2) @(negedge clk);
      check({name, "_ignored_busy_later"}, 64'(busy), 64'(0));
      check({name, "_ignored_hi"}, 64'(hi), 64'(m_hi));
      check({name, "_ignored_lo"}, 64'(lo), 64'(m_lo));
      return;
    end
    if (hazard) begin
      @(negedge clk);
      start = 1'b1;
      op    = 2'd1;
      a     = $urandom;
      b     = $urandom;
      we_lo = 1'b1;
      wdata = 32'h0000_ABCD;
      @(negedge clk);
      start = 1'b0;
      we_lo = 1'b0;
    end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_timeout_busy"}, 64'(busy), 64'(0));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    issue(2'd0, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5", 1'b0, 1'b0);
    check("mult_const_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("mult_const_lo", 64'(lo), 64'(32'hFFFF_FFF1));
    issue(2'd1, 32'hFFFF_FFFD, 32'd5, "multu_fffffffd_x5", 1'b0, 1'b0);
    check("multu_const_hi", 64'(hi), 64'(32'h0000_0004));
    check("multu_const_lo", 64'(lo), 64'(32'hFFFF_FFF1));

`ifdef MDU_DIV_EN
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 1'b0, 1'b0);
    check("div_const_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div_const_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    issue(2'd3, 32'hFFFF_FFF9, 32'd2, "divu_fffffff9_2", 1'b0, 1'b0);
    check("divu_const_lo", 64'(lo), 64'(32'h7FFF_FFFC));
    check("divu_const_hi", 64'(hi), 64'(32'h0000_0001));
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    issue(2'd2, 32'd5, 32'd0, "div_by_zero", 1'b0, 1'b0);
    check("divz_const_hi", 64'(hi), 64'(32'h11));
    check("divz_const_lo", 64'(lo), 64'(32'h22));
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0, 1'b0);
    check("divovf_const_lo", 64'(lo), 64'(32'h8000_0000));
    check("divovf_const_hi", 64'(hi), 64'(32'h0000_0000));
`else
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, "div_disabled", 1'b0, 1'b0);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2, "divu_disabled", 1'b0, 1'b0);
    check("div_disabled_const_hi", 64'(hi), 64'(32'h11));
`endif

    mt(1'b1, 1'b1, 32'h5555_AAAA);
    issue(2'd0, 32'h0000_1234, 32'h0000_5678, "hazard_mult", 1'b1, 1'b0);
    check("hazard_const_lo", 64'(lo), 64'(32'h0626_0060));

    issue(2'd0, 32'd3, 32'd4, "collide_mult", 1'b0, 1'b1);
    check("collide_const_hi", 64'(hi), 64'(32'h0));
    check("collide_const_lo", 64'(lo), 64'(32'd12));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 2)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else
        issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), "rand_op",
              1'($urandom_range(0, 5) == 0), 1'b0);
    end

    // Reset in the middle of a mult, with nonzero HI/LO beforehand.
    mt(1'b1, 1'b1, 32'h1234_5678);
    start = 1'b1;
    op    = 2'd0;
    a     = 32'd7;
    b     = 32'd6;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_busy_before", 64'(busy), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hi", 64'(hi), 64'(0));
    check("rst_mid_lo", 64'(lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_after_busy", 64'(busy), 64'(0));
    check("rst_after_hi", 64'(hi), 64'(0));
    check("rst_after_lo", 64'(lo), 64'(0));

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "post_reset_multu", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit holding the architectural HI/LO registers for the MIPS core. It sits directly downstream of the datapath's register-read stage: it consumes the two GPR operands (rs, rt) and an operation code that the controller decodes. It serves mult/multu/div/divu/mthi/mtlo and exposes HI/LO for mfhi/mflo. It raises `busy` so the controller can stall any instruction that touches HI/LO or starts a new operation.

## Interface
- `MULT_CYCLES`, default 5: busy duration in cycles for mult/multu (must be ≥ 1).
- `DIV_CYCLES`, default 10: busy duration in cycles for div/divu (must be ≥ 1).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; `reset`=0 clears all state immediately.
- `start` input, 1 bit: request to launch the operation given by `op` with operands `a`, `b`.
- `op` input, 2 bits: 0 = mult, 1 = multu, 2 = div, 3 = divu.
- `a` input, 32 bits: rs operand (multiplicand / dividend).
- `b` input, 32 bits: rt operand (multiplier / divisor).
- `we_hi` input, 1 bit: mthi write enable.
- `we_lo` input, 1 bit: mtlo write enable.
- `wdata` input, 32 bits: data for mthi/mtlo.
- `busy` output, 1 bit: operation in flight.
- `hi` output, 32 bits: HI register, driven directly from a flop.
- `lo` output, 32 bits: LO register, driven directly from a flop.

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN on a rising edge with `start`=1.
  - RUN → IDLE when the down-counter reaches its terminal count.
- Launch:
  - On the launching edge, capture the full 64-bit result into an internal pending register.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - `hi`/`lo` do not change at launch.
- mult: {HI,LO} = signed(a) × signed(b), 64-bit two's complement.
- multu: {HI,LO} = unsigned(a) × unsigned(b).
- div/divu, general case: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
  - Unsigned divide uses plain unsigned semantics.
- Signed overflow: 0x80000000 ÷ 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (b = 0): HI/LO are left unchanged at commit. `busy` still runs for the full `DIV_CYCLES`.
- Commit: on the edge where RUN terminates, write the pending result into HI/LO and deassert `busy`.
- `start` while `busy`=1: ignored. No restart, and the operands are not sampled.
- mthi/mtlo while idle:
  - `we_hi` writes `wdata` into HI on the edge.
  - `we_lo` writes `wdata` into LO on the edge.
  - If both are asserted, both registers get `wdata`.
- mthi/mtlo while `busy`=1: ignored. The controller must stall them.
- `start` and `we_hi`/`we_lo` on the same idle edge: `start` wins and the write is dropped.
- Reset, including in the middle of an operation:
  - `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0, pending register 0.
  - An in-flight result is discarded.

## Timing
- Launching edge = edge k (`start`=1 sampled while idle).
- `busy` is 1 from just after edge k to just after edge k+N, so exactly N cycles high. N = `MULT_CYCLES` or `DIV_CYCLES`.
- `hi`/`lo` take the new value at edge k+N, the same edge where `busy` falls.
- A new `start` is accepted at edge k+N+1 at the earliest. Back-to-back operations therefore have a throughput of one per N+1 cycles.
- mthi/mtlo latency: 1 cycle. The value is visible on `hi`/`lo` right after the write edge.
- `busy` is a registered output, not combinational on `start`. The controller stalls on `start` itself in the launch cycle.
- Asynchronous reset takes effect immediately. Release is synchronous to `clk` through normal flop behaviour.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: div/divu are implemented as specified above.
- Not defined:
  - The divider logic is compiled out.
  - `start` with `op`=2 or 3 is ignored: no busy, HI/LO unchanged.
  - mult/multu and mthi/mtlo are unaffected.
  - `DIV_CYCLES` is unused.

## Test plan
- Reset mid-mult:
  - Stimulus: start mult 7 × 6, then pull `reset` low during cycle 3.
  - Response: `busy`=0, `hi`=`lo`=0 immediately. After release, 20 idle cycles leave HI/LO at 0.
- Signed mult:
  - Stimulus: a = 0xFFFFFFFD (−3), b = 5.
  - Response: `busy` high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - multu with the same operands: HI = 0x00000004, LO = 0xFFFFFFF1.
- Division (requires `MDU_DIV_EN`):
  - div −7 ÷ 2: `busy` 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu 0xFFFFFFF9 ÷ 2: LO = 0x7FFFFFFC, HI = 1.
- Divide edge cases:
  - Preload HI = 0x11, LO = 0x22 via mthi/mtlo, then div by 0. `busy` lasts 10 cycles and HI/LO stay 0x11/0x22.
  - div 0x80000000 ÷ 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Hazards while busy:
  - Stimulus during a mult: assert `start` with different operands, plus `we_lo` with 0xABCD.
  - Response: the original result commits, both the new start and the write are dropped, and `busy` falls on schedule.
- Same-edge collision:
  - Stimulus: `start` and `we_hi` on the same idle edge.
  - Response: HI ends as the mult result, not `wdata`.
